// File: rtl/rv_fetch_aligner.sv
// Halfword realigner between the fetch port and the decompressing decoder: emits one
// 16/32-bit instruction per handshake with its PC. Optional fault tagging: RV_FETCH_ALIGNER_FAULT_EN.
module rv_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
`ifdef RV_FETCH_ALIGNER_FAULT_EN
    input  logic        in_fault,
    output logic        out_fault,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    logic [15:0] r_buf [3];
    logic [1:0]  r_cnt;
    logic [31:0] r_pc;
    logic        r_skip;

    logic [15:0] w_buf_nx [3];
    logic [1:0]  w_cnt_nx;
    logic [1:0]  w_pop;
    logic [1:0]  w_rem;
    logic        w_need1;
    logic        w_head_flt;
    logic        w_ofire;
    logic        w_ifire;
    logic [31:0] w_redir_pc;

`ifdef RV_FETCH_ALIGNER_FAULT_EN
    logic [2:0]  r_flt;
    logic [2:0]  w_flt_nx;

    assign w_head_flt = r_flt[0];
    assign out_fault  = r_flt[0] | (~w_need1 & r_flt[1]);
`else
    assign w_head_flt = 1'b0;
`endif

    // A faulted head is released as a single halfword so the fault can surface without waiting.
    assign w_need1   = (r_buf[0][1:0] != 2'b11) | w_head_flt;
    assign out_valid = w_need1 ? (r_cnt != 2'd0) : (r_cnt >= 2'd2);
    assign out_insn  = w_need1 ? {16'h0000, r_buf[0]} : {r_buf[1], r_buf[0]};
    assign out_pc    = r_pc;

    assign w_ofire    = out_valid & out_ready & ~redirect_valid;
    assign w_pop      = w_ofire ? (w_need1 ? 2'd1 : 2'd2) : 2'd0;
    assign w_rem      = r_cnt - w_pop;
    assign in_ready   = ~redirect_valid & (w_rem <= 2'd1);
    assign w_ifire    = in_valid & in_ready;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFE;

    // Pop shifts the survivors down; the pushed halfwords land right after them.
    always_comb begin
        w_buf_nx = r_buf;
`ifdef RV_FETCH_ALIGNER_FAULT_EN
        w_flt_nx = r_flt;
`endif
        unique case (w_pop)
            2'd1: begin
                w_buf_nx[0] = r_buf[1];
                w_buf_nx[1] = r_buf[2];
`ifdef RV_FETCH_ALIGNER_FAULT_EN
                w_flt_nx[0] = r_flt[1];
                w_flt_nx[1] = r_flt[2];
`endif
            end
            2'd2: begin
                w_buf_nx[0] = r_buf[2];
`ifdef RV_FETCH_ALIGNER_FAULT_EN
                w_flt_nx[0] = r_flt[2];
`endif
            end
            default: ;
        endcase
        w_cnt_nx = w_rem;
        if (w_ifire) begin
            if (r_skip) begin
                w_buf_nx[w_rem] = in_data[31:16];
                w_cnt_nx        = w_rem + 2'd1;
`ifdef RV_FETCH_ALIGNER_FAULT_EN
                w_flt_nx[w_rem] = in_fault;
`endif
            end else begin
                w_buf_nx[w_rem]        = in_data[15:0];
                w_buf_nx[w_rem + 2'd1] = in_data[31:16];
                w_cnt_nx               = w_rem + 2'd2;
`ifdef RV_FETCH_ALIGNER_FAULT_EN
                w_flt_nx[w_rem]        = in_fault;
                w_flt_nx[w_rem + 2'd1] = in_fault;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf  <= '{default: '0};
            r_cnt  <= '0;
            r_pc   <= {RESET_PC[31:1], 1'b0};
            r_skip <= RESET_PC[1];
`ifdef RV_FETCH_ALIGNER_FAULT_EN
            r_flt  <= '0;
`endif
        end else if (redirect_valid) begin
            r_cnt  <= '0;
            r_pc   <= w_redir_pc;
            r_skip <= w_redir_pc[1];
        end else begin
            r_buf <= w_buf_nx;
            r_cnt <= w_cnt_nx;
            r_pc  <= r_pc + {29'd0, w_pop, 1'b0};
            if (w_ifire)
                r_skip <= 1'b0;
`ifdef RV_FETCH_ALIGNER_FAULT_EN
            r_flt <= w_flt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_rv_fetch_aligner.sv
// Self-checking bench for rv_fetch_aligner; fault-tag scenario runs only with RV_FETCH_ALIGNER_FAULT_EN.
module tb_rv_fetch_aligner;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef RV_FETCH_ALIGNER_FAULT_EN
    logic        in_fault = 1'b0;
    logic        out_fault;
    logic        s_flt;
    logic        exp_flt [$];
    logic        flt_q   [$];
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] words    [$];
    logic [31:0] exp_insn [$];
    logic [31:0] exp_pc   [$];

    logic        s_ov, s_ir, s_ifire, s_ofire;
    logic [31:0] s_insn, s_pc;

    rv_fetch_aligner #(.RESET_PC(32'h0000_0100)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef RV_FETCH_ALIGNER_FAULT_EN
        .in_fault(in_fault),
        .out_fault(out_fault),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_insn(out_insn),
        .out_pc(out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        in_valid = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        in_data = '0; redirect_pc = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Drives one cycle of inputs, samples outputs at the falling edge, returns at posedge+1.
    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic ordy,
                               input logic rv, input logic [31:0] rpc);
        in_valid = v; in_data = d; out_ready = ordy; redirect_valid = rv; redirect_pc = rpc;
        @(negedge clock);
        s_ov = out_valid; s_insn = out_insn; s_pc = out_pc; s_ir = in_ready;
        s_ifire = v & in_ready;
        s_ofire = out_valid & ordy & ~rv;
`ifdef RV_FETCH_ALIGNER_FAULT_EN
        s_flt = out_fault;
`endif
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        drive_cycle(1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_pc !== 32'h100) begin
            errors++; $display("FAIL reset_pc got %h want 00000100", out_pc);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_stream();
        int first = -1;
        int last  = -1;
        logic [31:0] d;
        apply_reset();
        words = {}; exp_insn = {}; exp_pc = {};
        for (int i = 0; i < 4; i++) begin
            words.push_back(32'h0000_0013);
            exp_insn.push_back(32'h0000_0013);
            exp_pc.push_back(32'h100 + 32'(4 * i));
        end
        for (int cyc = 0; cyc < 40 && exp_insn.size() > 0; cyc++) begin
            d = (words.size() > 0) ? words[0] : 32'h0;
            drive_cycle(words.size() > 0, d, 1'b1, 1'b0, '0);
            if (s_ifire) void'(words.pop_front());
            if (s_ofire) begin
                checks++;
                if (s_insn !== exp_insn[0] || s_pc !== exp_pc[0]) begin
                    errors++;
                    $display("FAIL stream got %h@%h want %h@%h", s_insn, s_pc, exp_insn[0], exp_pc[0]);
                end
                void'(exp_insn.pop_front()); void'(exp_pc.pop_front());
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        checks++;
        if (exp_insn.size() != 0) begin
            errors++; $display("FAIL stream_drain got %0d pending want 0", exp_insn.size());
        end
        checks++;
        if (first != 1 || last != 4) begin
            errors++; $display("FAIL stream_timing got first %0d last %0d want 1 4", first, last);
        end
    endtask

    task automatic test_compressed_pair();
        apply_reset();
        drive_cycle(1'b1, 32'h4501_4081, 1'b0, 1'b0, '0);
        checks++;
        if (s_ifire !== 1'b1) begin
            errors++; $display("FAIL pair_accept got %b want 1", s_ifire);
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, '0);
        checks++;
        if (s_ir !== 1'b0 || s_ov !== 1'b1 || s_insn !== 32'h4081 || s_pc !== 32'h100) begin
            errors++;
            $display("FAIL pair_hold got ir %b ov %b %h@%h want 0 1 00004081@00000100", s_ir, s_ov, s_insn, s_pc);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (!s_ofire || s_insn !== 32'h4081 || s_pc !== 32'h100 || s_ir !== 1'b1) begin
            errors++;
            $display("FAIL pair_first got fire %b ir %b %h@%h want 1 1 00004081@00000100", s_ofire, s_ir, s_insn, s_pc);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (!s_ofire || s_insn !== 32'h4501 || s_pc !== 32'h102) begin
            errors++;
            $display("FAIL pair_second got fire %b %h@%h want 1 00004501@00000102", s_ofire, s_insn, s_pc);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (s_ov !== 1'b0 || s_pc !== 32'h104) begin
            errors++; $display("FAIL pair_empty got ov %b pc %h want 0 00000104", s_ov, s_pc);
        end
    endtask

    task automatic test_straddle();
        logic [31:0] d;
        apply_reset();
        words = {32'h0513_4081}; exp_insn = {}; exp_pc = {};
        exp_insn.push_back(32'h0000_4081); exp_pc.push_back(32'h100);
        exp_insn.push_back(32'h0000_0513); exp_pc.push_back(32'h102);
        exp_insn.push_back(32'h0000_4081); exp_pc.push_back(32'h106);
        for (int cyc = 0; cyc < 40 && exp_insn.size() > 0; cyc++) begin
            if (cyc == 4) words.push_back(32'h4081_0000);
            d = (words.size() > 0) ? words[0] : 32'h0;
            drive_cycle(words.size() > 0, d, 1'b1, 1'b0, '0);
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (s_ov !== 1'b0) begin
                    errors++; $display("FAIL straddle_wait cyc %0d got ov %b want 0", cyc, s_ov);
                end
            end
            if (s_ifire) void'(words.pop_front());
            if (s_ofire) begin
                checks++;
                if (s_insn !== exp_insn[0] || s_pc !== exp_pc[0]) begin
                    errors++;
                    $display("FAIL straddle got %h@%h want %h@%h", s_insn, s_pc, exp_insn[0], exp_pc[0]);
                end
                void'(exp_insn.pop_front()); void'(exp_pc.pop_front());
            end
        end
        checks++;
        if (exp_insn.size() != 0) begin
            errors++; $display("FAIL straddle_drain got %0d pending want 0", exp_insn.size());
        end
    endtask

    task automatic test_redirect();
        logic [31:0] d;
        apply_reset();
        drive_cycle(1'b1, 32'h4501_4081, 1'b0, 1'b0, '0);
        drive_cycle(1'b0, '0, 1'b1, 1'b1, 32'h0000_0202);
        checks++;
        if (s_ir !== 1'b0 || s_ov !== 1'b1) begin
            errors++; $display("FAIL redirect_cycle got ir %b ov %b want 0 1", s_ir, s_ov);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (s_ov !== 1'b0 || s_pc !== 32'h202) begin
            errors++; $display("FAIL redirect_flush got ov %b pc %h want 0 00000202", s_ov, s_pc);
        end
        words = {32'h4081_ABCD}; exp_insn = {32'h0000_4081}; exp_pc = {32'h202};
        for (int cyc = 0; cyc < 20 && exp_insn.size() > 0; cyc++) begin
            d = (words.size() > 0) ? words[0] : 32'h0;
            drive_cycle(words.size() > 0, d, 1'b1, 1'b0, '0);
            if (s_ifire) void'(words.pop_front());
            if (s_ofire) begin
                checks++;
                if (s_insn !== exp_insn[0] || s_pc !== exp_pc[0]) begin
                    errors++;
                    $display("FAIL redirect_out got %h@%h want %h@%h", s_insn, s_pc, exp_insn[0], exp_pc[0]);
                end
                void'(exp_insn.pop_front()); void'(exp_pc.pop_front());
            end
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (exp_insn.size() != 0 || s_ov !== 1'b0 || s_pc !== 32'h204) begin
            errors++;
            $display("FAIL redirect_after got pending %0d ov %b pc %h want 0 0 00000204", exp_insn.size(), s_ov, s_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        apply_reset();
        words = {32'h0000_0013, 32'h4501_4081, 32'h00A0_0093};
        exp_insn = {32'h0000_0013, 32'h0000_4081, 32'h0000_4501, 32'h00A0_0093};
        exp_pc   = {32'h100, 32'h104, 32'h106, 32'h108};
        for (int cyc = 0; cyc < 5; cyc++) begin
            drive_cycle(1'b1, words[0], 1'b0, 1'b0, '0);
            if (s_ifire) void'(words.pop_front());
            if (cyc >= 1) begin
                checks++;
                if (s_ir !== 1'b0 || s_insn !== 32'h13 || s_pc !== 32'h100) begin
                    errors++;
                    $display("FAIL stall cyc %0d got ir %b %h@%h want 0 00000013@00000100", cyc, s_ir, s_insn, s_pc);
                end
            end
        end
        for (int cyc = 0; cyc < 40 && exp_insn.size() > 0; cyc++) begin
            d = (words.size() > 0) ? words[0] : 32'h0;
            drive_cycle(words.size() > 0, d, 1'b1, 1'b0, '0);
            if (s_ifire) void'(words.pop_front());
            if (s_ofire) begin
                checks++;
                if (s_insn !== exp_insn[0] || s_pc !== exp_pc[0]) begin
                    errors++;
                    $display("FAIL release got %h@%h want %h@%h", s_insn, s_pc, exp_insn[0], exp_pc[0]);
                end
                void'(exp_insn.pop_front()); void'(exp_pc.pop_front());
            end
        end
        checks++;
        if (exp_insn.size() != 0) begin
            errors++; $display("FAIL release_drain got %0d pending want 0", exp_insn.size());
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        drive_cycle(1'b1, 32'h4081_1234, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (!s_ofire || s_insn !== 32'h4081 || s_pc !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL wrap_out got fire %b %h@%h want 1 00004081@fffffffe", s_ofire, s_insn, s_pc);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (s_ov !== 1'b0 || s_pc !== 32'h0) begin
            errors++; $display("FAIL wrap_pc got ov %b pc %h want 0 00000000", s_ov, s_pc);
        end
    endtask

    task automatic test_reset_straddle();
        apply_reset();
        drive_cycle(1'b1, 32'h0513_4081, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (s_ov !== 1'b0 || s_pc !== 32'h102) begin
            errors++; $display("FAIL rs_partial got ov %b pc %h want 0 00000102", s_ov, s_pc);
        end
        apply_reset();
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (s_ov !== 1'b0 || s_pc !== 32'h100) begin
            errors++; $display("FAIL rs_cleared got ov %b pc %h want 0 00000100", s_ov, s_pc);
        end
        drive_cycle(1'b1, 32'h0000_0013, 1'b1, 1'b0, '0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (!s_ofire || s_insn !== 32'h13 || s_pc !== 32'h100) begin
            errors++;
            $display("FAIL rs_fresh got fire %b %h@%h want 1 00000013@00000100", s_ofire, s_insn, s_pc);
        end
    endtask

`ifdef RV_FETCH_ALIGNER_FAULT_EN
    task automatic test_fault();
        logic [31:0] d;
        apply_reset();
        words = {32'h0513_4081, 32'h4081_0000}; flt_q = {1'b0, 1'b1};
        exp_insn = {32'h0000_4081, 32'h0000_0513, 32'h0000_4081};
        exp_pc   = {32'h100, 32'h102, 32'h106};
        exp_flt  = {1'b0, 1'b1, 1'b1};
        for (int cyc = 0; cyc < 20 && exp_insn.size() > 0; cyc++) begin
            d = (words.size() > 0) ? words[0] : 32'h0;
            in_fault = (flt_q.size() > 0) ? flt_q[0] : 1'b0;
            drive_cycle(words.size() > 0, d, 1'b1, 1'b0, '0);
            if (s_ifire) begin
                void'(words.pop_front()); void'(flt_q.pop_front());
            end
            if (s_ofire) begin
                checks++;
                if (s_pc !== exp_pc[0] || s_flt !== exp_flt[0] ||
                    (!exp_flt[0] && s_insn !== exp_insn[0])) begin
                    errors++;
                    $display("FAIL fault got %h@%h f%b want %h@%h f%b", s_insn, s_pc, s_flt,
                             exp_insn[0], exp_pc[0], exp_flt[0]);
                end
                void'(exp_insn.pop_front()); void'(exp_pc.pop_front()); void'(exp_flt.pop_front());
            end
        end
        checks++;
        if (exp_insn.size() != 0) begin
            errors++; $display("FAIL fault_drain got %0d pending want 0", exp_insn.size());
        end
        // Single faulted 32-bit-start halfword must still surface.
        in_fault = 1'b0;
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_0302);
        in_fault = 1'b1;
        drive_cycle(1'b1, 32'h0013_FFFF, 1'b0, 1'b0, '0);
        in_fault = 1'b0;
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (!s_ofire || s_flt !== 1'b1 || s_pc !== 32'h302) begin
            errors++; $display("FAIL fault_head got fire %b f%b pc %h want 1 1 00000302", s_ofire, s_flt, s_pc);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        checks++;
        if (s_ov !== 1'b0 || s_pc !== 32'h304) begin
            errors++; $display("FAIL fault_head_pop got ov %b pc %h want 0 00000304", s_ov, s_pc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_compressed_pair();
        test_straddle();
        test_redirect();
        test_backpressure();
        test_wrap();
        test_reset_straddle();
`ifdef RV_FETCH_ALIGNER_FAULT_EN
        test_fault();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
